// File: rtl/ddr_req_adapter.sv
// ddr_req_adapter: turns matrix_unit's single-request DDR pulses into a
// valid/ready memory-bus request and returns a one-cycle completion pulse.
// Optional watchdog: define DDR_TIMEOUT_EN to abandon unanswered transactions
// after TimeoutCycles cycles (completion pulse still issued, error flagged).
module ddr_req_adapter #(
    parameter int unsigned AddrWidth     = 20,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] ddr_address_i,
    input  logic                 ddr_r_en_i,
    input  logic                 ddr_w_en_i,
    input  logic [DataWidth-1:0] ddr_w_data_i,
    output logic [DataWidth-1:0] ddr_r_data_o,
    output logic                 ddr_r_valid_o,
    output logic                 ddr_w_done_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_req_we_o,
    output logic [AddrWidth-1:0] mem_req_addr_o,
    output logic [DataWidth-1:0] mem_req_wdata_o,
    input  logic                 mem_rd_valid_i,
    input  logic [DataWidth-1:0] mem_rd_data_i,
    input  logic                 mem_wr_ack_i,
    output logic                 busy_o,
    output logic                 error_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } state_e;

    state_e state_q;

    if (TimeoutCycles < 2) begin : g_timeout_check
        $error("TimeoutCycles must be at least 2");
    end

`ifdef DDR_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;

    logic [CntWidth-1:0] cnt_q;
    logic                expire;
    logic                finishing;

    // A genuine handshake or response in the expiry cycle wins over the watchdog.
    assign finishing = (state_q == REQ     && mem_req_ready_i) ||
                       (state_q == WAIT_RD && mem_rd_valid_i)  ||
                       (state_q == WAIT_WR && mem_wr_ack_i);
    assign expire    = (state_q != IDLE) &&
                       (cnt_q >= CntWidth'(TimeoutCycles - 1)) && !finishing;

    // Watchdog counter: zero while idle, so it starts at 0 on entry to REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    assign busy_o = (state_q != IDLE);

    // Request/response FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            ddr_r_data_o    <= '0;
            ddr_r_valid_o   <= 1'b0;
            ddr_w_done_o    <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_we_o    <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_wdata_o <= '0;
            error_o         <= 1'b0;
        end else begin
            ddr_r_valid_o <= 1'b0;
            ddr_w_done_o  <= 1'b0;

            if ((mem_rd_valid_i && state_q != WAIT_RD) ||
                (mem_wr_ack_i && state_q != WAIT_WR)) begin
                error_o <= 1'b1;
            end
            if ((ddr_r_en_i || ddr_w_en_i) && state_q != IDLE) begin
                error_o <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ddr_r_en_i && ddr_w_en_i) begin
                        error_o <= 1'b1;
                    end else if (ddr_r_en_i || ddr_w_en_i) begin
                        mem_req_addr_o  <= ddr_address_i;
                        mem_req_we_o    <= ddr_w_en_i;
                        if (ddr_w_en_i) begin
                            mem_req_wdata_o <= ddr_w_data_i;
                        end
                        mem_req_valid_o <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state_q         <= mem_req_we_o ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (mem_rd_valid_i) begin
                        ddr_r_data_o  <= mem_rd_data_i;
                        ddr_r_valid_o <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                WAIT_WR: begin
                    if (mem_wr_ack_i) begin
                        ddr_w_done_o <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

`ifdef DDR_TIMEOUT_EN
            // Abandon the transaction but still complete it so matrix_unit never stalls.
            if (expire) begin
                mem_req_valid_o <= 1'b0;
                error_o         <= 1'b1;
                state_q         <= IDLE;
                if (mem_req_we_o) begin
                    ddr_w_done_o <= 1'b1;
                end else begin
                    ddr_r_valid_o <= 1'b1;
                    ddr_r_data_o  <= '0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ddr_req_adapter.sv
// Self-checking bench for ddr_req_adapter (default build, watchdog disabled).
// Transactions are described by their timing (bus stall, response latency)
// and the expected bus/completion behaviour is derived from that description.
module tb_ddr_req_adapter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ddr_address;
    logic          ddr_r_en;
    logic          ddr_w_en;
    logic [DW-1:0] ddr_w_data;
    logic [DW-1:0] ddr_r_data;
    logic          ddr_r_valid;
    logic          ddr_w_done;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_ack;
    logic          busy;
    logic          error;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference expectations maintained by the bench
    logic [DW-1:0] rdata_exp;
    logic [DW-1:0] wdata_exp;
    logic [AW-1:0] addr_exp;
    logic          we_exp;
    logic          err_exp;

    ddr_req_adapter #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .TimeoutCycles(1024)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .ddr_address_i(ddr_address),
        .ddr_r_en_i(ddr_r_en),
        .ddr_w_en_i(ddr_w_en),
        .ddr_w_data_i(ddr_w_data),
        .ddr_r_data_o(ddr_r_data),
        .ddr_r_valid_o(ddr_r_valid),
        .ddr_w_done_o(ddr_w_done),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_we_o(mem_req_we),
        .mem_req_addr_o(mem_req_addr),
        .mem_req_wdata_o(mem_req_wdata),
        .mem_rd_valid_i(mem_rd_valid),
        .mem_rd_data_i(mem_rd_data),
        .mem_wr_ack_i(mem_wr_ack),
        .busy_o(busy),
        .error_o(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Outputs expected while idle with nothing in flight
    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, DW'(mem_req_valid), '0);
        chk({tag, "_rvalid"}, DW'(ddr_r_valid), '0);
        chk({tag, "_wdone"}, DW'(ddr_w_done), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_rdata"}, ddr_r_data, rdata_exp);
        chk({tag, "_err"}, DW'(error), DW'(err_exp));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_idle("idle");
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, ddr_r_data, '0);
        chk({tag, "_rvalid"}, DW'(ddr_r_valid), '0);
        chk({tag, "_wdone"}, DW'(ddr_w_done), '0);
        chk({tag, "_valid"}, DW'(mem_req_valid), '0);
        chk({tag, "_we"}, DW'(mem_req_we), '0);
        chk({tag, "_addr"}, DW'(mem_req_addr), '0);
        chk({tag, "_wdata"}, mem_req_wdata, '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_err"}, DW'(error), '0);
    endtask

    // One transaction, starting at a negedge with the adapter idle (or in its
    // completion cycle) and ending at the negedge of its own completion cycle.
    // stall: cycles with ready low; lat: response cycles after the handshake.
    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] resp, input int stall, input int lat,
                       input bit poke);
        ddr_address = a;
        ddr_w_data  = d;
        ddr_r_en    = !wr;
        ddr_w_en    = wr;
        addr_exp    = a;
        we_exp      = wr;
        if (wr) wdata_exp = d;
        @(negedge clk);
        ddr_r_en    = 1'b0;
        ddr_w_en    = 1'b0;
        ddr_address = AW'($urandom);
        ddr_w_data  = rnd_data();
        chk("prev_rvalid_drop", DW'(ddr_r_valid), '0);
        chk("prev_wdone_drop", DW'(ddr_w_done), '0);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk("req_valid", DW'(mem_req_valid), '1 >> (DW - 1));
            chk("req_we", DW'(mem_req_we), DW'(we_exp));
            chk("req_addr", DW'(mem_req_addr), DW'(addr_exp));
            chk("req_wdata", mem_req_wdata, wdata_exp);
            chk("req_busy", DW'(busy), DW'(1));
            mem_req_ready = (i == stall);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("post_hs_valid", DW'(mem_req_valid), '0);
        chk("post_hs_busy", DW'(busy), DW'(1));
        if (poke) begin
            ddr_address = AW'($urandom);
            ddr_r_en    = wr;
            ddr_w_en    = !wr;
            err_exp     = 1'b1;
        end
        for (int j = 1; j < lat; j++) begin
            chk("wait_rvalid", DW'(ddr_r_valid), '0);
            chk("wait_wdone", DW'(ddr_w_done), '0);
            chk("wait_busy", DW'(busy), DW'(1));
            @(negedge clk);
            ddr_r_en = 1'b0;
            ddr_w_en = 1'b0;
        end
        if (wr) begin
            mem_wr_ack = 1'b1;
        end else begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = resp;
        end
        @(negedge clk);
        ddr_r_en     = 1'b0;
        ddr_w_en     = 1'b0;
        mem_wr_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = rnd_data();
        if (!wr) rdata_exp = resp;
        chk("done_rvalid", DW'(ddr_r_valid), DW'(!wr));
        chk("done_wdone", DW'(ddr_w_done), DW'(wr));
        chk("done_rdata", ddr_r_data, rdata_exp);
        chk("done_busy", DW'(busy), '0);
        chk("done_valid", DW'(mem_req_valid), '0);
        chk("done_err", DW'(error), DW'(err_exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        ddr_address   = '0;
        ddr_r_en      = 1'b0;
        ddr_w_en      = 1'b0;
        ddr_w_data    = '0;
        mem_req_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        mem_wr_ack    = 1'b0;
        rdata_exp     = '0;
        wdata_exp     = '0;
        addr_exp      = '0;
        we_exp        = 1'b0;
        err_exp       = 1'b0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Read 0x12, ready at once, response 3 cycles after handshake
        txn(1'b0, 20'h12, '0, DW'(8'hA5), 0, 3, 1'b0);
        idle(2);

        // Write 0x7, ready stalled 4 cycles (5 valid cycles)
        txn(1'b1, 20'h7, DW'(8'h3C), '0, 4, 2, 1'b0);
        idle(1);

        // Back-to-back reads: second launched in the first's completion cycle
        txn(1'b0, 20'h100, '0, rnd_data(), 1, 1, 1'b0);
        txn(1'b0, 20'h104, '0, rnd_data(), 0, 2, 1'b0);
        idle(1);

        // Randomized mix of reads and writes, with and without idle gaps
        for (int t = 0; t < 24; t++) begin
            txn(1'($urandom_range(0, 1)), AW'($urandom), rnd_data(), rnd_data(),
                $urandom_range(0, 4), $urandom_range(1, 4), 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // Enable pulse while busy: ignored, transaction completes, error set
        txn(1'b0, 20'h55, '0, rnd_data(), 1, 3, 1'b1);
        idle(2);

        // Reset clears the sticky flag
        rst_n = 1'b0;
        #1;
        rdata_exp = '0;
        wdata_exp = '0;
        err_exp   = 1'b0;
        chk_all_zero("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Both enables in IDLE: no request, error set and sticky
        ddr_address = 20'h33;
        ddr_r_en    = 1'b1;
        ddr_w_en    = 1'b1;
        err_exp     = 1'b1;
        @(negedge clk);
        ddr_r_en = 1'b0;
        ddr_w_en = 1'b0;
        chk_idle("both_en");
        idle(3);
        txn(1'b1, 20'h9, rnd_data(), '0, 2, 1, 1'b0);
        idle(1);

        rst_n = 1'b0;
        #1;
        rdata_exp = '0;
        wdata_exp = '0;
        err_exp   = 1'b0;
        chk_all_zero("reset3");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Stray write ack in IDLE
        mem_wr_ack = 1'b1;
        err_exp    = 1'b1;
        @(negedge clk);
        mem_wr_ack = 1'b0;
        chk_idle("stray_ack");

        // Read aborted by reset while waiting for data
        ddr_address = 20'h44;
        ddr_r_en    = 1'b1;
        @(negedge clk);
        ddr_r_en = 1'b0;
        chk("abort_req_valid", DW'(mem_req_valid), DW'(1));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("abort_wait_busy", DW'(busy), DW'(1));
        chk("abort_wait_err", DW'(error), DW'(1));
        rst_n = 1'b0;
        #1;
        rdata_exp = '0;
        wdata_exp = '0;
        err_exp   = 1'b0;
        chk_all_zero("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Stale read response after reset: ignored, error set
        mem_rd_valid = 1'b1;
        mem_rd_data  = rnd_data();
        err_exp      = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk_idle("stale_rd");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
